systolic_pe_v2: RTL

SYSTOLIC_PE_V2 -- requirements
Module: systolic_pe_v2

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_mac.sv | 82 ++++++++
 rtl/systolic_pe_v2.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Brief    : Shared types and default widths for the systolic processing element
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

  localparam int C_DATA_W_DEFAULT = 8;
  localparam int C_ACC_W_DEFAULT  = 32;

  typedef enum logic [0:0] {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pe_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac
// Brief    : Combinational multiply-add with operand extension and clamp/wrap
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT,
  parameter int ACC_W  = C_ACC_W_DEFAULT,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic [DATA_W-1:0] i_weight,
  input  logic [DATA_W-1:0] i_operand,
  input  logic [ACC_W-1:0]  i_addend,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_raw;
  logic             w_ovf;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] w_a;
      logic signed [PROD_W-1:0] w_b;
      logic signed [PROD_W-1:0] w_prod;

      assign w_a        = {{DATA_W{i_weight[DATA_W-1]}}, i_weight};
      assign w_b        = {{DATA_W{i_operand[DATA_W-1]}}, i_operand};
      assign w_prod     = w_a * w_b;
      assign w_prod_ext = ACC_W'(w_prod);
      assign w_raw      = w_prod_ext + i_addend;
      // Two's-complement overflow: like-signed operands yield an opposite-signed result
      assign w_ovf      = (w_prod_ext[ACC_W-1] == i_addend[ACC_W-1]) &&
                          (w_raw[ACC_W-1] != w_prod_ext[ACC_W-1]);
    end else begin : g_unsigned
      logic [PROD_W-1:0] w_a;
      logic [PROD_W-1:0] w_b;
      logic [PROD_W-1:0] w_prod;
      logic              w_carry;

      assign w_a        = {{DATA_W{1'b0}}, i_weight};
      assign w_b        = {{DATA_W{1'b0}}, i_operand};
      assign w_prod     = w_a * w_b;
      assign w_prod_ext = ACC_W'(w_prod);
      assign {w_carry, w_raw} = {1'b0, w_prod_ext} + {1'b0, i_addend};
      assign w_ovf      = w_carry;
    end
  endgenerate

  generate
    if (SAT != 0) begin : g_sat
      logic [ACC_W-1:0] w_limit;

      // Overflow direction follows the product sign, since both operands agree in sign
      always_comb begin
        w_limit = '1;
        if (SIGNED != 0) begin
          if (w_prod_ext[ACC_W-1]) begin
            w_limit = {1'b1, {(ACC_W-1){1'b0}}};
          end else begin
            w_limit = {1'b0, {(ACC_W-1){1'b1}}};
          end
        end
      end

      assign o_sum = w_ovf ? w_limit : w_raw;
    end else begin : g_wrap
      assign o_sum = w_raw;
    end
  endgenerate

  assign o_ovf = w_ovf;

endmodule
`default_nettype wire

// File: rtl/systolic_pe_v2.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe_v2
// Brief    : Systolic-array PE, weight-stationary or output-stationary with drain
// Revision : 1.0 - initial release
// ============================================================================
module systolic_pe_v2
  import pe_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT,
  parameter int ACC_W  = C_ACC_W_DEFAULT,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_weight,
  input  logic              i_weight_we,
  input  logic              i_swap,
  input  logic [DATA_W-1:0] i_west,
  input  logic              i_west_valid,
  input  logic [ACC_W-1:0]  i_north,
  input  logic              i_north_valid,
  input  logic              i_clear,
  input  logic              i_drain,
  output logic [DATA_W-1:0] o_east,
  output logic              o_east_valid,
  output logic [ACC_W-1:0]  o_south,
  output logic              o_south_valid,
  output logic              o_shadow_full,
  output logic              o_sat
);

  pe_state_e         r_state;
  pe_state_e         w_state_nxt;

  logic [DATA_W-1:0] r_active_w;
  logic [DATA_W-1:0] r_shadow_w;
  logic              r_shadow_full;
  logic [DATA_W-1:0] r_east;
  logic              r_east_valid;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_south;
  logic              r_south_valid;
  logic              r_sat;

  logic              w_os;
  logic              w_clear;
  logic              w_ws_emit;
  logic              w_acc_en;
  logic              w_drain_start;
  logic              w_drain_pass;
  logic [ACC_W-1:0]  w_addend;
  logic [ACC_W-1:0]  w_mac_sum;
  logic              w_mac_ovf;
  logic              w_swap_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Mode is only looked at in RUN, so a change while draining waits for the return
  always_comb begin
    w_state_nxt   = r_state;
    w_os          = 1'b0;
    w_clear       = 1'b0;
    w_ws_emit     = 1'b0;
    w_acc_en      = 1'b0;
    w_drain_start = 1'b0;
    w_drain_pass  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (pe_mode_e'(i_mode) == PE_OS) begin
          w_os    = 1'b1;
          w_clear = i_clear;
          if (i_drain) begin
            w_drain_start = 1'b1;
            w_state_nxt   = DRAIN;
          end else begin
            w_acc_en = i_west_valid & i_north_valid;
          end
        end else begin
          w_ws_emit = i_west_valid;
        end
      end
      DRAIN: begin
        w_os         = 1'b1;
        w_clear      = i_clear;
        w_drain_pass = 1'b1;
        if (!i_drain) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign w_addend = w_os ? r_acc : (i_north_valid ? i_north : '0);

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .i_weight  (r_active_w),
    .i_operand (i_west),
    .i_addend  (w_addend),
    .o_sum     (w_mac_sum),
    .o_ovf     (w_mac_ovf)
  );

  assign w_swap_ok = i_swap & r_shadow_full;

  // A write coinciding with a swap refills the shadow, so the full flag stays set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active_w    <= '0;
      r_shadow_w    <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      if (w_swap_ok) begin
        r_active_w <= r_shadow_w;
      end
      if (i_weight_we) begin
        r_shadow_w    <= i_weight;
        r_shadow_full <= 1'b1;
      end else if (w_swap_ok) begin
        r_shadow_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_east       <= '0;
      r_east_valid <= 1'b0;
    end else begin
      r_east       <= i_west;
      r_east_valid <= i_west_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_clear || w_drain_start) begin
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= w_mac_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_clear) begin
      r_sat <= 1'b0;
    end else if ((w_acc_en || w_ws_emit) && w_mac_ovf) begin
      r_sat <= 1'b1;
    end
  end

  // Drain start emits the accumulator as it stood before any same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_south       <= '0;
      r_south_valid <= 1'b0;
    end else if (w_ws_emit) begin
      r_south       <= w_mac_sum;
      r_south_valid <= 1'b1;
    end else if (w_drain_start) begin
      r_south       <= r_acc;
      r_south_valid <= 1'b1;
    end else if (w_drain_pass) begin
      r_south       <= i_north;
      r_south_valid <= i_north_valid;
    end else begin
      r_south_valid <= 1'b0;
    end
  end

  assign o_east        = r_east;
  assign o_east_valid  = r_east_valid;
  assign o_south       = r_south;
  assign o_south_valid = r_south_valid;
  assign o_shadow_full = r_shadow_full;
  assign o_sat         = r_sat;

endmodule
`default_nettype wire
